// File: rtl/bus_arb_pkg.sv
// Shared definitions for local-bus arbiters: FSM state encoding, default
// timing constants and a round-robin pick helper usable by any arbiter.
package bus_arb_pkg;

  // One-hot arbiter states
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,  // bus owned by the CPU, HOLD low
    ST_HREQ  = 5'b00010,  // HOLD raised, waiting for HLDA
    ST_GRANT = 5'b00100,  // one requester owns the bus
    ST_GAP   = 5'b01000,  // single dead cycle between tenures
    ST_HDROP = 5'b10000   // HOLD released, waiting for HLDA to fall
  } arb_state_e;

  localparam int DEF_MAX_TENURE   = 64;
  localparam int DEF_HLDA_TIMEOUT = 1024;

  // Widest requester vector the pick helper handles
  localparam int RR_MAX   = 8;
  localparam int RR_PTR_W = 3;

  // Round-robin pick: one-hot of the first set bit of req at index >= ptr,
  // wrapping modulo n. Only the low n bits of req take part.
  function automatic logic [RR_MAX-1:0] rr_pick(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_PTR_W-1:0] ptr,
    input int unsigned         n
  );
    logic [RR_MAX-1:0] win;
    logic              found;
    int unsigned       idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      // ptr < n and i < n, so one subtraction is enough to wrap
      idx = 32'(ptr) + i;
      if (idx >= n) begin
        idx = idx - n;
      end
      if (!found && (i < n) && req[idx[RR_PTR_W-1:0]]) begin
        win[idx[RR_PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: chooses the first active request at or
// after the pointer and reports it both one-hot and as an index.
module rr_picker
  import bus_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  logic [RR_MAX-1:0] req_pad;
  logic [RR_MAX-1:0] win_pad;
  logic [PTR_W-1:0]  idx_terms [N_REQ];

  assign req_pad    = RR_MAX'(req);
  assign win_pad    = rr_pick(req_pad, RR_PTR_W'(ptr), N_REQ);
  assign win_onehot = N_REQ'(win_pad);
  assign win_valid  = |req;

  // Each one-hot bit contributes its own index; at most one is non-zero
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_idx
    assign idx_terms[gi] = win_onehot[gi] ? PTR_W'(gi) : '0;
  end

  // OR-reduce the per-bit index terms into the winner index
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      win_idx = win_idx | idx_terms[i];
    end
  end

endmodule

// File: rtl/dma_hold_arbiter.sv
// Lends the 8088 local bus to N_REQ bus masters through the HOLD/HLDA
// handshake, granting one requester at a time in round-robin order.
module dma_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int N_REQ        = 2,
  parameter int MAX_TENURE   = DEF_MAX_TENURE,
  parameter int HLDA_TIMEOUT = DEF_HLDA_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             HLDA,
  input  logic [N_REQ-1:0] REQ,
  output logic             HOLD,
  output logic [N_REQ-1:0] GNT,
  output logic             PREEMPT,
  output logic             BUSY,
  output logic             HOLD_ERR
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TEN_W = $clog2(MAX_TENURE);
  localparam int TO_W  = $clog2(HLDA_TIMEOUT);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(MAX_TENURE - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(HLDA_TIMEOUT - 1);

  arb_state_e       state_reg,    state_next;
  logic             hold_reg,     hold_next;
  logic [N_REQ-1:0] gnt_reg,      gnt_next;
  logic             preempt_reg,  preempt_next;
  logic             busy_reg,     busy_next;
  logic             hold_err_reg, hold_err_next;
  logic [PTR_W-1:0] ptr_reg,      ptr_next;
  logic [PTR_W-1:0] owner_reg,    owner_next;
  logic [TEN_W-1:0] tenure_reg,   tenure_next;
  logic [TO_W-1:0]  timeout_reg,  timeout_next;

  logic [N_REQ-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic             owner_req;
  logic             others_req;

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req        (REQ),
    .ptr        (ptr_reg),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .win_valid  (pick_valid)
  );

  // The registered grant doubles as the owner mask
  assign owner_req  = |(REQ & gnt_reg);
  assign others_req = |(REQ & ~gnt_reg);

  assign HOLD     = hold_reg;
  assign GNT      = gnt_reg;
  assign PREEMPT  = preempt_reg;
  assign BUSY     = busy_reg;
  assign HOLD_ERR = hold_err_reg;

  // Next-state and next-output logic; every output is registered
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    preempt_next  = preempt_reg;
    hold_err_next = hold_err_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    tenure_next   = tenure_reg;
    timeout_next  = timeout_reg;

    case (state_reg)
      ST_IDLE: begin
        gnt_next     = '0;
        preempt_next = 1'b0;
        tenure_next  = '0;
        timeout_next = '0;
        if (|REQ) begin
          state_next = ST_HREQ;
        end
      end

      ST_HREQ: begin
        // HOLD is kept high even after the timeout: the 8088 must see
        // HLDA answered before HOLD may be released
        if (timeout_reg == TO_LAST) begin
          hold_err_next = 1'b1;
        end else begin
          timeout_next = timeout_reg + TO_W'(1);
        end
        if (HLDA) begin
          timeout_next = '0;
          if (pick_valid) begin
            state_next  = ST_GRANT;
            gnt_next    = pick_onehot;
            owner_next  = pick_idx;
            tenure_next = '0;
          end else begin
            state_next = ST_HDROP;
          end
        end
      end

      ST_GRANT: begin
        if (!owner_req) begin
          state_next   = ST_GAP;
          gnt_next     = '0;
          preempt_next = 1'b0;
          tenure_next  = '0;
          ptr_next     = (owner_reg == PTR_LAST) ? '0 : owner_reg + PTR_W'(1);
        end else begin
          if (tenure_reg != TEN_LAST) begin
            tenure_next = tenure_reg + TEN_W'(1);
          end
          // Saturated counter keeps this armed for late competitors;
          // once raised, PREEMPT holds until the owner lets go
          if ((tenure_reg == TEN_LAST) && others_req) begin
            preempt_next = 1'b1;
          end
          if (!HLDA) begin
            hold_err_next = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (pick_valid) begin
          state_next  = ST_GRANT;
          gnt_next    = pick_onehot;
          owner_next  = pick_idx;
          tenure_next = '0;
        end else begin
          state_next = ST_HDROP;
        end
      end

      ST_HDROP: begin
        if (!HLDA) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        gnt_next     = '0;
        preempt_next = 1'b0;
      end
    endcase

    hold_next = (state_next == ST_HREQ) || (state_next == ST_GRANT) ||
                (state_next == ST_GAP);
    busy_next = |gnt_next;
  end

  // State and output registers; reset clears outputs without waiting for CLK
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg    <= ST_IDLE;
      hold_reg     <= 1'b0;
      gnt_reg      <= '0;
      preempt_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      hold_err_reg <= 1'b0;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      tenure_reg   <= '0;
      timeout_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      hold_reg     <= hold_next;
      gnt_reg      <= gnt_next;
      preempt_reg  <= preempt_next;
      busy_reg     <= busy_next;
      hold_err_reg <= hold_err_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      tenure_reg   <= tenure_next;
      timeout_reg  <= timeout_next;
    end
  end

endmodule
